// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the int_ctrl interrupt controller: register offsets,
// FSM state encoding and the default bridge base address.
package int_ctrl_pkg;

  localparam logic [31:0] DefaultBaseAddr = 32'h0000_7F20;

  localparam logic [1:0] OffMask = 2'd0;
  localparam logic [1:0] OffPend = 2'd1;
  localparam logic [1:0] OffCur  = 2'd2;
  localparam logic [1:0] OffEoi  = 2'd3;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StService = 2'd2
  } intc_state_e;

  function automatic logic [5:0] onehot6(input logic [2:0] id);
    return 6'(1) << id;
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder: reports whether any bit is set and the
// index of the lowest set bit.
module int_prio_enc #(
  parameter int unsigned N = 6
) (
  input  logic [N-1:0] i_vec,
  output logic         o_any,
  output logic [2:0]   o_id
);

  always_comb begin
    o_any = |i_vec;
    o_id  = '0;
    // Walk downwards so the lowest set index is the final assignment.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (i_vec[i]) o_id = 3'(i);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller driving CP0 HWInt[7:2] with an ack/EOI handshake.
// Define INTC_LEVEL_EN to make PEND follow the registered level of irq_src.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int unsigned NSRC      = 6,
  parameter logic [31:0] BASE_ADDR = DefaultBaseAddr
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  input  logic [31:0]     PrAddr,
  input  logic [31:0]     PrWD,
  input  logic            PrWe,
  output logic [31:0]     PrRD,
  output logic [5:0]      HWInt,
  input  logic            int_ack
);

  localparam logic [5:0] SrcBits = 6'((7'd1 << NSRC) - 7'd1);

  intc_state_e     r_state, w_state_d;
  logic [NSRC-1:0] r_mask, r_pend;
  logic [NSRC-1:0] w_mask_d, w_pend_d, w_elig, w_cur_oh;
  logic [2:0]      r_cur_id, w_win_id;
  logic            w_win_any, w_cur_valid, w_ack;
  logic            w_hit, w_wr_mask, w_wr_pend, w_wr_eoi;
  logic [1:0]      w_off;

  assign w_hit     = (PrAddr[31:4] == BASE_ADDR[31:4]);
  assign w_off     = PrAddr[3:2];
  assign w_wr_mask = w_hit & PrWe & (w_off == OffMask);
  assign w_wr_pend = w_hit & PrWe & (w_off == OffPend);
  assign w_wr_eoi  = w_hit & PrWe & (w_off == OffEoi);

  assign w_ack    = (r_state == StReq) & int_ack;
  assign w_cur_oh = NSRC'(1) << r_cur_id;
  assign w_mask_d = w_wr_mask ? PrWD[NSRC-1:0] : r_mask;
  assign w_elig   = r_mask & r_pend;

`ifdef INTC_LEVEL_EN
  logic w_unused;
  assign w_unused = ^{PrAddr[1:0], PrWD[31:NSRC], w_wr_pend};
  assign w_pend_d = irq_src;
`else
  logic            w_unused;
  logic [NSRC-1:0] r_irq_q, w_rise, w_clr;
  assign w_unused = ^{PrAddr[1:0], PrWD[31:NSRC]};
  assign w_rise   = irq_src & ~r_irq_q;
  assign w_clr    = (w_wr_pend ? PrWD[NSRC-1:0] : '0) | (w_ack ? w_cur_oh : '0);
  // A rising edge overrides a same-cycle clear of the same bit.
  assign w_pend_d = (r_pend & ~w_clr) | w_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_irq_q <= '0;
    else       r_irq_q <= irq_src;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask <= '0;
      r_pend <= '0;
    end else begin
      r_mask <= w_mask_d;
      r_pend <= w_pend_d;
    end
  end

  int_prio_enc #(
    .N (NSRC)
  ) u_prio (
    .i_vec (w_elig),
    .o_any (w_win_any),
    .o_id  (w_win_id)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_cur_id <= '0;
    end else begin
      r_state <= w_state_d;
      if ((r_state == StIdle) && w_win_any) r_cur_id <= w_win_id;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:    if (w_win_any) w_state_d = StReq;
      // Withdrawal looks at next-state MASK/PEND so a software clear drops the request at once.
      StReq: begin
        if (w_ack)                                    w_state_d = StService;
        else if (~|(w_mask_d & w_pend_d & w_cur_oh)) w_state_d = StIdle;
      end
      StService: if (w_wr_eoi) w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_comb begin
    HWInt       = '0;
    w_cur_valid = 1'b0;
    unique case (r_state)
      StReq: begin
        HWInt       = onehot6(r_cur_id) & SrcBits;
        w_cur_valid = 1'b1;
      end
      StService: w_cur_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    PrRD = '0;
    if (w_hit) begin
      unique case (w_off)
        OffMask: PrRD = 32'(r_mask);
        OffPend: PrRD = 32'(r_pend);
        OffCur:  PrRD = {w_cur_valid, 28'b0, r_cur_id};
        default: PrRD = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: directed handshake/decode cases plus randomized
// scenarios whose service order is predicted from pending/mask sets.
module tb_int_ctrl;

  localparam logic [31:0] AMask = 32'h0000_7F20;
  localparam logic [31:0] APend = 32'h0000_7F24;
  localparam logic [31:0] ACur  = 32'h0000_7F28;
  localparam logic [31:0] AEoi  = 32'h0000_7F2C;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic [5:0]  irq_src = '0;
  logic [31:0] PrAddr  = '0;
  logic [31:0] PrWD    = '0;
  logic        PrWe    = 1'b0;
  logic        int_ack = 1'b0;
  logic [31:0] PrRD;
  logic [5:0]  HWInt;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  int_ctrl #(
    .NSRC      (6),
    .BASE_ADDR (32'h0000_7F20)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .irq_src (irq_src),
    .PrAddr  (PrAddr),
    .PrWD    (PrWD),
    .PrWe    (PrWe),
    .PrRD    (PrRD),
    .HWInt   (HWInt),
    .int_ack (int_ack)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int lowest(input logic [5:0] v);
    for (int i = 0; i < 6; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    PrAddr = a;
    PrWD   = d;
    PrWe   = 1'b1;
    tick();
    PrWe   = 1'b0;
    PrAddr = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    PrAddr = a;
    #1;
    d      = PrRD;
    PrAddr = '0;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (HWInt != 0) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
    n_vec++;
    n_err++;
    $display("FAIL req_timeout: HWInt %h after 12 cycles, expected a request", HWInt);
  endtask

  // Monitor: every new request presented on HWInt is matched against the scoreboard.
  logic [5:0] mon_prev = '0;
  int         mon_id;
  always @(negedge clk) begin
    if (reset) begin
      mon_prev = '0;
    end else begin
      if (HWInt != 0 && HWInt != mon_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_req", 32'(HWInt), 32'h0);
        end else begin
          mon_id = exp_q.pop_front();
          check("req_order", 32'(HWInt), 32'(6'(1) << mon_id));
        end
      end
      mon_prev = HWInt;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit          ok;
    int          busy;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_hwint", 32'(HWInt), 32'h0);
    bus_read(AMask, rd); check("rst_mask", rd, 32'h0);
    bus_read(APend, rd); check("rst_pend", rd, 32'h0);
    bus_read(ACur, rd);  check("rst_cur", rd, 32'h0);
    reset = 1'b0;
    tick();

    // Latency, then asynchronous reset while requesting
    bus_write(AMask, 32'h1);
    exp_q.push_back(0);
    irq_src = 6'b000001;
    tick();
    check("lat_idle", 32'(HWInt), 32'h0);
    bus_read(APend, rd); check("lat_pend", rd, 32'h1);
    tick();
    check("lat_req", 32'(HWInt), 32'h1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("arst_hwint", 32'(HWInt), 32'h0);
    bus_read(APend, rd); check("arst_pend", rd, 32'h0);
    bus_read(AMask, rd); check("arst_mask", rd, 32'h0);
    irq_src = '0;
    tick();
    reset = 1'b0;
    tick();

    // Priority and ack/EOI handshake
    bus_write(AMask, 32'h3F);
    exp_q.push_back(1);
    exp_q.push_back(3);
    irq_src = 6'b001010;
    tick();
    tick();
    check("prio_hw", 32'(HWInt), 32'h2);
    bus_read(ACur, rd); check("prio_cur", rd, 32'h8000_0001);
    ack();
    check("ack_hw", 32'(HWInt), 32'h0);
    bus_read(APend, rd); check("ack_pend", rd, 32'h8);
    bus_read(ACur, rd);  check("svc_cur", rd, 32'h8000_0001);
    bus_write(AEoi, 32'h0);
    bus_read(ACur, rd); check("eoi_valid", 32'(rd[31]), 32'h0);
    tick();
    check("next_hw", 32'(HWInt), 32'h8);
    bus_write(AEoi, 32'h0);
    check("eoi_in_req", 32'(HWInt), 32'h8);
    ack();
    bus_write(AEoi, 32'h0);
    irq_src = '0;
    tick();

    // Masked pending stays quiet; unmask requests; W1C withdraws
    bus_write(AMask, 32'h0);
    irq_src = 6'b000100;
    tick();
    busy = 0;
    repeat (20) begin
      tick();
      if (HWInt != 0) busy++;
    end
    check("masked_quiet", 32'(busy), 32'h0);
    bus_read(APend, rd); check("masked_pend", rd, 32'h4);
    exp_q.push_back(2);
    bus_write(AMask, 32'h4);
    check("unmask_idle", 32'(HWInt), 32'h0);
    tick();
    check("unmask_req", 32'(HWInt), 32'h4);
    bus_write(APend, 32'h4);
    check("w1c_withdraw", 32'(HWInt), 32'h0);
    bus_read(ACur, rd); check("withdraw_valid", 32'(rd[31]), 32'h0);
    irq_src = '0;
    tick();
    tick();

    // Set wins over a same-cycle clear
    bus_write(AMask, 32'h0);
    irq_src = 6'b000100;
    bus_write(APend, 32'h4);
    bus_read(APend, rd); check("set_wins", rd, 32'h4);
    bus_write(APend, 32'h4);
    bus_read(APend, rd); check("w1c_clear", rd, 32'h0);
    irq_src = '0;
    tick();

    // Bus decode and stray ack
    irq_src = 6'b010000;
    tick();
    irq_src = '0;
    bus_read(APend, rd);        check("dec_pend", rd, 32'h10);
    bus_read(32'h0000_7F30, rd); check("dec_miss", rd, 32'h0);
    bus_read(AEoi, rd);         check("dec_eoi", rd, 32'h0);
    bus_write(32'h0000_7F10, 32'h3F);
    bus_read(AMask, rd);        check("dec_nowrite", rd, 32'h0);
    ack();
    bus_read(APend, rd);        check("ack_idle", rd, 32'h10);
    bus_write(APend, 32'h3F);
    tick();

    // Randomized scenarios
    for (int s = 0; s < 40; s++) begin
      logic [5:0] m, a, b, e, allm, rest;
      int         first, total;
      m = 6'($urandom);
      a = 6'($urandom_range(1, 63));
      b = 6'($urandom) & ~a;
      bus_write(APend, 32'h3F);
      bus_write(AMask, 32'(m));
      e     = a & m;
      first = lowest(e);
      if (first >= 0) exp_q.push_back(first);
      irq_src = a;
      if (first >= 0) wait_req(ok);
      else repeat (3) tick();
      irq_src = a | b;
      allm = (a | b) & m;
      rest = allm;
      if (first >= 0) rest[first] = 1'b0;
      for (int i = 0; i < 6; i++) if (rest[i]) exp_q.push_back(i);
      total = $countones(allm);
      for (int k = 0; k < total; k++) begin
        wait_req(ok);
        if (!ok) break;
        repeat ($urandom_range(0, 2)) tick();
        ack();
        repeat ($urandom_range(0, 2)) tick();
        bus_write(AEoi, $urandom);
      end
      repeat (2) tick();
      bus_read(APend, rd); check("rand_pend", rd, 32'((a | b) & ~m));
      irq_src = '0;
      tick();
    end

    repeat (5) tick();
    check("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
